// File: rtl/acc4_stage.sv
// 4-bit accumulator stage: accept an operand, execute LOAD/ADD/SUB/CLR, hold the result
// until consumed. Define ACC4_SAT_EN to saturate/clamp ADD/SUB instead of wrapping.
module acc4_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic [1:0] op,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] acc,
  output logic       carry,
  output logic       zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] op_cnt
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpSub  = 2'b10;
  localparam logic [1:0] OpClr  = 2'b11;

  state_e     state_q, state_d;
  logic [3:0] data_q, data_d;
  logic [1:0] opr_q, opr_d;
  logic [3:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] sum, diff;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    opr_d   = opr_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, acc_q} + {1'b0, data_q};
    // Bit 4 of the difference is the borrow (old acc < operand).
    diff    = {1'b0, acc_q} - {1'b0, data_q};
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          opr_d   = op;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StHold;
        cnt_d   = cnt_q + 4'd1;
        case (opr_q)
          OpLoad: begin
            acc_d   = data_q;
            carry_d = 1'b0;
          end
          OpAdd: begin
            carry_d = sum[4];
`ifdef ACC4_SAT_EN
            acc_d   = sum[4] ? 4'hF : sum[3:0];
`else
            acc_d   = sum[3:0];
`endif
          end
          OpSub: begin
            carry_d = diff[4];
`ifdef ACC4_SAT_EN
            acc_d   = diff[4] ? 4'h0 : diff[3:0];
`else
            acc_d   = diff[3:0];
`endif
          end
          OpClr: begin
            acc_d   = 4'h0;
            carry_d = 1'b0;
          end
          default: ;
        endcase
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    zero_d = (acc_d == 4'h0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= 4'h0;
      opr_q   <= OpLoad;
      acc_q   <= 4'h0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      cnt_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      opr_q   <= opr_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !reset;
  assign out_valid = (state_q == StHold);
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_acc4_stage.sv
// Scoreboard bench for acc4_stage: expected results queued at accept, compared when presented.
module tb_acc4_stage;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, carry, zero, out_valid, out_ready;
  logic [3:0] in_data, acc, op_cnt;
  logic [1:0] op;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] acc;
    logic       carry;
    logic       zero;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_acc;
  logic       m_carry;
  logic [3:0] m_cnt;

  acc4_stage dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .op       (op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .acc      (acc),
    .carry    (carry),
    .zero     (zero),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .op_cnt   (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one operation; pushes the expected result.
  task automatic model_push(input logic [1:0] o, input logic [3:0] d);
    logic [4:0] r;
    exp_t e;
    case (o)
      2'b00: begin m_acc = d; m_carry = 1'b0; end
      2'b01: begin
        r = m_acc + d;
        m_carry = (r > 5'd15);
`ifdef ACC4_SAT_EN
        m_acc = m_carry ? 4'hF : r[3:0];
`else
        m_acc = r[3:0];
`endif
      end
      2'b10: begin
        m_carry = (m_acc < d);
`ifdef ACC4_SAT_EN
        m_acc = m_carry ? 4'h0 : 4'(m_acc - d);
`else
        m_acc = 4'(m_acc - d);
`endif
      end
      default: begin m_acc = 4'h0; m_carry = 1'b0; end
    endcase
    m_cnt = m_cnt + 4'd1;
    e.acc = m_acc; e.carry = m_carry; e.zero = (m_acc == 4'h0); e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("in_ready_in_reset", in_ready, 0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    m_acc = 4'h0; m_carry = 1'b0; m_cnt = 4'h0;
    sb_q.delete();
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_state", {acc, carry, zero, op_cnt}, {4'h0, 1'b0, 1'b1, 4'h0});
  endtask

  // Issue one op at the current negedge (block must be idle); stall = HOLD cycles with out_ready=0.
  task automatic do_op(input logic [1:0] o, input logic [3:0] d, input int stall);
    exp_t e;
    logic [3:0] acc_hold, cnt_hold;
    check_eq("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; op = o; in_data = d;
    out_ready = (stall == 0);
    model_push(o, d);
    @(negedge clk);
    in_valid = (stall > 0);
    in_data = 4'($urandom_range(0, 15)); op = 2'($urandom_range(0, 3));
    check_eq("exec_out_valid", out_valid, 0);
    check_eq("exec_in_ready", in_ready, 0);
    @(negedge clk);
    check_eq("hold_out_valid", out_valid, 1);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_eq("result", {acc, carry, zero, op_cnt}, e);
    end
    acc_hold = acc; cnt_hold = op_cnt;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_out_valid", out_valid, 1);
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_acc_cnt", {acc, op_cnt}, {acc_hold, cnt_hold});
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("back_idle", out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = 4'h0; op = 2'b00;
    m_acc = 4'h0; m_carry = 1'b0; m_cnt = 4'h0;
    do_reset();
    do_op(2'b00, 4'h7, 0);                       // LOAD 7
    do_op(2'b00, 4'h9, 0); do_op(2'b01, 4'h8, 0); // 9 + 8
    do_op(2'b00, 4'h3, 0); do_op(2'b10, 4'h5, 0); // 3 - 5
    do_op(2'b00, 4'h5, 0); do_op(2'b10, 4'h5, 0); // 5 - 5
    do_op(2'b00, 4'h2, 5);                        // stalled HOLD
    for (int i = 0; i < 8; i++) do_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0);
    check_eq("cnt_wrap", op_cnt, 0);
    do_op(2'b11, 4'hA, 0);                        // CLR
    do_op(2'b00, 4'h4, 0);
    // ADD 1 aborted by reset during EXEC.
    in_valid = 1'b1; op = 2'b01; in_data = 4'h1;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_acc", acc, 0);
    check_eq("abort_zero", zero, 1);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_cnt", op_cnt, 0);
    @(negedge clk);
    check_eq("abort_no_hold", out_valid, 0);
    check_eq("abort_idle", in_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
